// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - forward-select codes driven onto the execute-stage operand muxes
//   - multi-cycle sequencing FSM state type
//   - performance counter width
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from writeback stage
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from memory stage

    typedef enum logic [1:0] {
        RUN,
        BUSY,
        DONE
    } hz_state_t;

    localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/hazard_controller_forward_select.sv
// -----------------------------------------------------------------------------
// forward_select
// Priority comparator choosing the forwarding source for one execute operand.
// The memory stage holds the youngest result, so it beats writeback; register
// 0 is hard-wired and never forwarded.
// Ports:
//   rs           source register of the operand in execute
//   rd_m, reg_write_m   memory-stage destination and write enable
//   rd_w, reg_write_w   writeback-stage destination and write enable
//   sel          FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module forward_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Hazard and sequencing controller for the 24-bit five-stage pipeline.
//   - operand forwarding selectors for execute (valid only in RUN)
//   - load-use stall, taken-branch flush
//   - multi-cycle execute sequencing: RUN -> BUSY -> DONE -> RUN, holding
//     fetch/decode/execute for MC_LAT-1 cycles while bubbling memory
// Ports:
//   clk, reset (async, active-high)
//   Rs1D/Rs2D, Rs1E/Rs2E, RdE/RdM/RdW, RegWriteM/W, MemToRegE,
//   BranchTakenE, MultiCycleE                         : pipeline status in
//   data1/data2ForwardSelector                         : forwarding selects
//   StallF/D/E, FlushD/E/M, ExecBusy                   : stage controls
//   StallCount, FlushCount                             : perf counters
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating perf
// counters; when undefined both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned MC_LAT     = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemToRegE,
    input  logic                  BranchTakenE,
    input  logic                  MultiCycleE,
    output logic [1:0]            data1ForwardSelector,
    output logic [1:0]            data2ForwardSelector,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  ExecBusy,
    output logic [PERF_CNT_W-1:0] StallCount,
    output logic [PERF_CNT_W-1:0] FlushCount
);

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [1:0] sel1_raw, sel2_raw;
    logic       lu;
    logic       mc_ctl;    // multi-cycle op holding the front of the pipe
    logic       pipe_ctl;  // normal load-use / branch handling allowed
    logic       fwd_en;    // forwarding selects are meaningful this cycle
    logic       act;

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (sel1_raw)
    );

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (sel2_raw)
    );

    assign lu = MemToRegE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_ctl    = 1'b0;
        pipe_ctl  = 1'b0;
        fwd_en    = 1'b0;
        case (state)
            RUN: begin
                // Operands are captured in the first cycle of a multi-cycle
                // op, so forwarding stays live here even when one starts.
                fwd_en = 1'b1;
                if (MultiCycleE) begin
                    mc_ctl    = 1'b1;
                    cnt_nxt   = CNT_W'(MC_LAT - 2);
                    state_nxt = (MC_LAT == 2) ? DONE : BUSY;
                end else begin
                    pipe_ctl = 1'b1;
                end
            end
            BUSY: begin
                mc_ctl  = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The op is still in execute and retires this cycle;
                // MultiCycleE refers to it and must not restart the sequence.
                pipe_ctl  = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Outputs are held low for the whole time reset is asserted, including
    // the combinational forwarding/hazard paths.
    assign act = ~reset;

    assign StallF   = act & (mc_ctl | (pipe_ctl & ~BranchTakenE & lu));
    assign StallD   = act & (mc_ctl | (pipe_ctl & ~BranchTakenE & lu));
    assign StallE   = act & mc_ctl;
    assign FlushM   = act & mc_ctl;
    assign ExecBusy = act & mc_ctl;
    assign FlushD   = act & pipe_ctl & BranchTakenE;
    assign FlushE   = act & pipe_ctl & (BranchTakenE | lu);

    assign data1ForwardSelector = (act & fwd_en) ? sel1_raw : FWD_RF;
    assign data2ForwardSelector = (act & fwd_en) ? sel2_raw : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallD && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_CNT_W'(1);
            end
            if ((FlushD || FlushE) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + PERF_CNT_W'(1);
            end
        end
    end

    assign StallCount = stall_cnt;
    assign FlushCount = flush_cnt;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Self-checking bench for hazard_controller. Two instances share all inputs:
// one with MC_LAT = 4, one with MC_LAT = 2. Expected outputs come from a
// cycle-level reference model that tracks each multi-cycle op by its age in
// cycles. Directed steps follow the test plan, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, MemToRegE, BranchTakenE, MultiCycleE;

    logic [1:0]  s1_a, s2_a, s1_b, s2_b;
    logic        sf_a, sd_a, se_a, fd_a, fe_a, fm_a, eb_a;
    logic        sf_b, sd_b, se_b, fd_b, fe_b, fm_b, eb_b;
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
    logic [10:0] obs_a, obs_b;

    always #5 clk = ~clk;

    hazard_controller #(.REG_ADDR_W(4), .MC_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
        .BranchTakenE(BranchTakenE), .MultiCycleE(MultiCycleE),
        .data1ForwardSelector(s1_a), .data2ForwardSelector(s2_a),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
        .FlushD(fd_a), .FlushE(fe_a), .FlushM(fm_a), .ExecBusy(eb_a),
        .StallCount(sc_a), .FlushCount(fc_a)
    );

    hazard_controller #(.REG_ADDR_W(4), .MC_LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
        .BranchTakenE(BranchTakenE), .MultiCycleE(MultiCycleE),
        .data1ForwardSelector(s1_b), .data2ForwardSelector(s2_b),
        .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
        .FlushD(fd_b), .FlushE(fe_b), .FlushM(fm_b), .ExecBusy(eb_b),
        .StallCount(sc_b), .FlushCount(fc_b)
    );

    // {sel1, sel2, StallF, StallD, StallE, FlushD, FlushE, FlushM, ExecBusy}
    assign obs_a = {s1_a, s2_a, sf_a, sd_a, se_a, fd_a, fe_a, fm_a, eb_a};
    assign obs_b = {s1_b, s2_b, sf_b, sd_b, se_b, fd_b, fe_b, fm_b, eb_b};

    int     cmp_n = 0;
    int     err_n = 0;
    int     age[2];       // cycles since the current multi-cycle op started, -1 idle
    int     lat_tab[2];
    longint m_sc[2];
    longint m_fc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [3:0] rs);
        if (RegWriteM && RdM != 4'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 4'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Age of the op in execute this cycle; a new op starts at age 0 in RUN.
    function automatic int eff_age(input int i);
        if (age[i] >= 0) return age[i];
        return MultiCycleE ? 0 : -1;
    endfunction

    function automatic logic [10:0] expect_out(input int i);
        int         a;
        int         l;
        logic       lu;
        logic [1:0] e1, e2;
        logic       sf, sd, se, fd, fe, fm, eb;
        if (reset) return '0;
        a  = eff_age(i);
        l  = lat_tab[i];
        lu = MemToRegE && RdE != 4'd0 && (RdE == Rs1D || RdE == Rs2D);
        e1 = (a <= 0) ? fwd_ref(Rs1E) : 2'b00;
        e2 = (a <= 0) ? fwd_ref(Rs2E) : 2'b00;
        {sf, sd, se, fd, fe, fm, eb} = '0;
        if (a >= 0 && a <= l - 2) begin
            sf = 1'b1; sd = 1'b1; se = 1'b1; fm = 1'b1; eb = 1'b1;
        end else if (BranchTakenE) begin
            fd = 1'b1; fe = 1'b1;
        end else if (lu) begin
            sf = 1'b1; sd = 1'b1; fe = 1'b1;
        end
        return {e1, e2, sf, sd, se, fd, fe, fm, eb};
    endfunction

    function automatic logic [31:0] perf_exp(input longint v);
`ifdef HAZARD_PERF_CNT_EN
        if (reset) return '0;
        return (v > 64'hffff_ffff) ? 32'hffff_ffff : 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    // Sample mid-cycle, compare, advance the model, return at posedge+1.
    task automatic tick(input string tag);
        logic [10:0] e;
        int          a;
        @(negedge clk);
        chk($sformatf("%s/out_a", tag), 32'(obs_a), 32'(expect_out(0)));
        chk($sformatf("%s/out_b", tag), 32'(obs_b), 32'(expect_out(1)));
        chk($sformatf("%s/sc_a", tag), sc_a, perf_exp(m_sc[0]));
        chk($sformatf("%s/fc_a", tag), fc_a, perf_exp(m_fc[0]));
        chk($sformatf("%s/sc_b", tag), sc_b, perf_exp(m_sc[1]));
        chk($sformatf("%s/fc_b", tag), fc_b, perf_exp(m_fc[1]));
        for (int i = 0; i < 2; i++) begin
            e = expect_out(i);
            if (reset) begin
                age[i]  = -1;
                m_sc[i] = 0;
                m_fc[i] = 0;
            end else begin
                if (e[5]) m_sc[i]++;
                if (e[3] || e[2]) m_fc[i]++;
                a = eff_age(i);
                if (a < 0 || a + 1 == lat_tab[i]) age[i] = -1;
                else age[i] = a + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 4'd0; Rs2D = 4'd0; Rs1E = 4'd0; Rs2E = 4'd0;
        RdE = 4'd0; RdM = 4'd0; RdW = 4'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemToRegE = 1'b0;
        BranchTakenE = 1'b0; MultiCycleE = 1'b0;
    endtask

    function automatic logic [3:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat_a;
        logic [4:0] pat_b;
        lat_tab[0] = 4;
        lat_tab[1] = 2;
        for (int i = 0; i < 2; i++) begin
            age[i] = -1; m_sc[i] = 0; m_fc[i] = 0;
        end

        // Reset state, with inputs that would otherwise raise controls.
        idle_inputs();
        reset = 1'b1;
        MemToRegE = 1'b1; RdE = 4'd5; Rs1D = 4'd5; MultiCycleE = 1'b1;
        RegWriteM = 1'b1; RdM = 4'd3; Rs1E = 4'd3;
        #2;
        chk("reset_out_a", 32'(obs_a), 32'd0);
        chk("reset_out_b", 32'(obs_b), 32'd0);
        tick("reset");
        idle_inputs();
        reset = 1'b0;
        tick("idle");

        // Forwarding priority.
        RdM = 4'd3; RdW = 4'd3; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 4'd3;
        #1 chk("fwd_mem", 32'(s1_a), 32'(2'b10));
        tick("fwd_mem");
        RegWriteM = 1'b0;
        #1 chk("fwd_wb", 32'(s1_a), 32'(2'b01));
        tick("fwd_wb");
        RegWriteM = 1'b1; Rs1E = 4'd0; RdM = 4'd0; RdW = 4'd0;
        #1 chk("fwd_r0", 32'(s1_a), 32'(2'b00));
        tick("fwd_r0");
        idle_inputs();

        // Load-use, one cycle, then cleared; RdE = 0 never stalls.
        MemToRegE = 1'b1; RdE = 4'd5; Rs2D = 4'd5;
        #1 chk("lu_fire", 32'({sf_a, sd_a, fe_a}), 32'(3'b111));
        tick("lu_fire");
        MemToRegE = 1'b0;
        #1 chk("lu_clear", 32'({sf_a, sd_a, fe_a}), 32'(3'b000));
        tick("lu_clear");
        MemToRegE = 1'b1; RdE = 4'd0; Rs2D = 4'd0;
        #1 chk("lu_r0", 32'({sf_a, sd_a, fe_a}), 32'(3'b000));
        tick("lu_r0");

        // Branch overrides load-use.
        RdE = 4'd5; Rs2D = 4'd5; BranchTakenE = 1'b1;
        #1 chk("br_over_lu", 32'({sf_a, sd_a, fd_a, fe_a}), 32'(4'b0011));
        tick("br_over_lu");
        idle_inputs();
        tick("idle");

        // Multi-cycle held high for five cycles: restart after DONE.
        pat_a = 5'b10111;
        pat_b = 5'b10101;
        MultiCycleE = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("mc_a_%0d", k), 32'({sd_a, fm_a, eb_a}), 32'({3{pat_a[k]}}));
            chk($sformatf("mc_b_%0d", k), 32'({sd_b, fm_b, eb_b}), 32'({3{pat_b[k]}}));
            tick($sformatf("mc_%0d", k));
        end
        MultiCycleE = 1'b0;
        for (int k = 0; k < 4; k++) tick("mc_drain");

        // Async reset while dut_a is in BUSY.
        MultiCycleE = 1'b1;
        tick("mc_start");
        MultiCycleE = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_busy_a", 32'(obs_a), 32'd0);
        chk("rst_busy_b", 32'(obs_b), 32'd0);
        tick("rst_busy");
        reset = 1'b0;
        #1 chk("post_rst_idle", 32'(eb_a), 32'd0);
        tick("post_rst");
        MultiCycleE = 1'b1;
        #1 chk("post_rst_start", 32'(eb_a), 32'd1);
        tick("post_rst_start");
        MultiCycleE = 1'b0;
        for (int k = 0; k < 3; k++) tick("post_rst_drain");

        // Perf counters: load-use + one 4-cycle op + one branch.
        reset = 1'b1;
        tick("perf_rst");
        reset = 1'b0;
        MemToRegE = 1'b1; RdE = 4'd5; Rs1D = 4'd5;
        tick("perf_lu");
        idle_inputs();
        MultiCycleE = 1'b1;
        tick("perf_mc");
        MultiCycleE = 1'b0;
        for (int k = 0; k < 3; k++) tick("perf_mc_run");
        BranchTakenE = 1'b1;
        tick("perf_br");
        BranchTakenE = 1'b0;
        tick("perf_idle");
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", sc_a, 32'd4);
        chk("perf_flush", fc_a, 32'd2);
`else
        chk("perf_stall", sc_a, 32'd0);
        chk("perf_flush", fc_a, 32'd0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            Rs1D = rnd_reg(); Rs2D = rnd_reg(); Rs1E = rnd_reg(); Rs2E = rnd_reg();
            RdE = rnd_reg(); RdM = rnd_reg(); RdW = rnd_reg();
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemToRegE    = ($urandom_range(0, 2) == 0);
            BranchTakenE = ($urandom_range(0, 4) == 0);
            MultiCycleE  = ($urandom_range(0, 7) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            tick("rand");
        end
        reset = 1'b0;
        idle_inputs();
        tick("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard and sequencing controller for the 24-bit five-stage pipeline.
- Drives the operand-forwarding selectors of the execute stage.
- Detects load-use hazards, flushes on taken branches, and sequences multi-cycle execute operations by stalling fetch, decode and execute for a fixed latency.
- Sits beside the pipeline registers; all stage-register enable and flush controls come from this block.

Parameters:
- REG_ADDR_W, 4, width of register-file addresses.
- MC_LAT, 4, total execute latency in cycles of a multi-cycle op; legal range 2..15.
- CNT_W, 4, width of the multi-cycle countdown counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  REG_ADDR_W  source registers of the instruction in decode
- Rs1E, Rs2E  in  REG_ADDR_W  source registers of the instruction in execute
- RdE, RdM, RdW  in  REG_ADDR_W  destination registers in execute, memory and writeback
- RegWriteM, RegWriteW  in  1  destination write enables in memory and writeback
- MemToRegE  in  1  instruction in execute is a load
- BranchTakenE  in  1  branch resolved taken in execute
- MultiCycleE  in  1  instruction in execute is a multi-cycle op
- data1ForwardSelector, data2ForwardSelector  out  2  00 = register file, 01 = writeback, 10 = memory
- StallF, StallD, StallE  out  1  hold the corresponding stage register
- FlushD, FlushE, FlushM  out  1  insert a bubble into the corresponding stage register
- ExecBusy  out  1  a multi-cycle op occupies execute
- StallCount, FlushCount  out  32  performance counters

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset is asserted:
  - state = RUN, counter = 0, perf counters = 0.
  - All stall and flush outputs = 0; both selectors = 00; ExecBusy = 0.
- Forwarding is combinational, per operand X in {1, 2}:
  - Select 10 if RegWriteM and RdM == RsXE and RdM != 0.
  - Else select 01 if RegWriteW and RdW == RsXE and RdW != 0.
  - Else select 00.
  - Memory beats writeback when both match.
  - Register 0 is never forwarded.
- Selectors are valid only in RUN. In BUSY and DONE they are forced to 00, because the datapath latched the multi-cycle operands in the first cycle.
- Load-use hazard (combinational): LU = MemToRegE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D). When LU fires: StallF = StallD = FlushE = 1 for one cycle.
- Branch: BranchTakenE gives FlushD = FlushE = 1 in the same cycle and overrides LU (StallF/StallD not asserted).
- Multi-cycle FSM states: RUN, BUSY, DONE.
  - RUN with MultiCycleE = 1 (cycle t): StallF = StallD = StallE = FlushM = 1 and ExecBusy = 1. Counter loads MC_LAT-2. Next state is DONE if MC_LAT == 2, else BUSY.
  - BUSY: the same four controls plus ExecBusy = 1. Counter decrements each cycle. When the counter reads 1 (or 0 on entry), next state is DONE.
  - DONE: no stalls, ExecBusy = 0. MultiCycleE is ignored because the same op is still in execute and leaves at the end of this cycle. Next state is RUN.
  - Total stall cycles = MC_LAT-1. The op leaves execute at the end of cycle t+MC_LAT-1.
- Priorities:
  - While in BUSY, or in RUN with MultiCycleE = 1, LU and BranchTakenE are ignored and FlushE is never asserted.
  - MultiCycleE together with BranchTakenE is illegal; the multi-cycle path wins.
- Reset mid-operation returns immediately to RUN with all controls deasserted; the in-flight op is abandoned.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - StallCount increments on every cycle with StallD = 1.
  - FlushCount increments on every cycle with FlushE = 1 or FlushD = 1 (one count per cycle).
  - Both saturate at all-ones.
- Undefined: both outputs tied to 0 and no counter flops are synthesised.

Decomposition:
- Package hazard_pkg holds:
  - forward-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the FSM state enum (RUN, BUSY, DONE);
  - the 32-bit counter width constant.
- One sub-module, forward_select: combinational priority comparator for one operand, instantiated twice.

Test Plan:
- Forwarding priority: RdM = RdW = 3, both RegWrite = 1, Rs1E = 3 -> data1ForwardSelector = 10. Then RegWriteM = 0 -> 01. Then Rs1E = 0 with Rd = 0 -> 00.
- Load-use: MemToRegE = 1, RdE = 5, Rs2D = 5 -> StallF = StallD = FlushE = 1 for exactly one cycle; same stimulus with RdE = 0 -> no stall.
- Branch over load-use: LU condition plus BranchTakenE = 1 -> FlushD = FlushE = 1, StallF = StallD = 0.
- Multi-cycle, MC_LAT = 4: MultiCycleE held high from cycle t -> stalls and FlushM high in cycles t..t+2, DONE in t+3, RUN in t+4. A new MultiCycleE at t+4 restarts the sequence. Repeat with MC_LAT = 2 -> exactly one stall cycle.
- Reset mid-BUSY: async reset pulse at t+1 -> all outputs 0 immediately, state RUN after release.
- With HAZARD_PERF_CNT_EN: one load-use stall plus one 4-cycle multi-cycle op plus one branch -> StallCount = 4, FlushCount = 2.
